world_map_arbiter: RTL and testbench
====================================

Name: world_map_arbiter

Overview:
- Shares the single read port of the world map memory (2-bit cell codes) between two requesters:
  - the display scanner, which feeds the World input of the pixel colorizer;
  - the robot simulator's sensor lookups.
- Display lookups have strict priority and fixed latency, so World data stays pixel-aligned.
- A delayed copy of video_on is produced alongside the display data, so colorizer inputs arrive together.
- Robot lookups use a req/ack handshake and fill idle slots.

Parameters:
ADDR_W, 14, map address width (128x128 cells)
RD_LAT, 1, map memory read latency in cycles from mem_addr to mem_data (1..4)
STARVE_MAX, 16, consecutive denied bot cycles that set bot_starved (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
vid_req  in  1  display lookup request this cycle (single-cycle, no handshake)
vid_addr  in  ADDR_W  display map address, sampled with vid_req
vid_on_in  in  1  raw video_on from timing generator
vid_valid  out  1  vid_data valid (response to vid_req)
vid_data  out  2  World code for display
vid_on_out  out  1  vid_on_in delayed to align with vid_data
bot_req  in  1  robot lookup request, held high until bot_ack
bot_addr  in  ADDR_W  robot map address, stable while bot_req high
bot_ack  out  1  one-cycle pulse: bot_data valid, request complete
bot_data  out  2  World code for robot
bot_starved  out  1  sticky flag: bot denied STARVE_MAX consecutive cycles
mem_addr  out  ADDR_W  registered address to map memory
mem_data  in  2  map memory read data

Behaviour:
- Reset state: all outputs 0; tag pipeline empty; bot FSM in B_IDLE; wait counter 0.
- Latency L = RD_LAT + 2 cycles, fixed.
  - Cycle t: grant decided.
  - Edge t+1: mem_addr registered.
  - mem_data is valid RD_LAT cycles later.
  - Result is captured into vid_data or bot_data registers on the following edge.
- Arbitration, evaluated every cycle:
  - If vid_req = 1: grant video, with mem_addr <= vid_addr.
  - Else, if bot FSM is in B_IDLE and bot_req = 1: grant bot, with mem_addr <= bot_addr, and FSM goes to B_WAIT.
  - Else: no grant; mem_addr holds its value.
- Tag pipeline: an L-1 deep shift register of {valid, owner} tracks each grant. At the output stage:
  - owner = video: vid_data <= mem_data, vid_valid <= 1.
  - owner = bot: bot_data <= mem_data, bot_ack <= 1.
  - Otherwise vid_valid and bot_ack are 0. vid_data and bot_data hold their last value.
- vid_on_out: vid_on_in through an L-stage shift register, independent of vid_req. A vid_req on the same cycle as vid_on_in therefore emerges aligned with it.
- Bot FSM:
  - B_IDLE -> B_WAIT on bot grant.
  - B_WAIT -> B_ACK when the bot tag reaches the output stage; bot_ack is high for exactly this one cycle.
  - B_ACK -> B_IDLE unconditionally.
  - bot_req is ignored in B_WAIT and B_ACK; at most one bot request is outstanding.
  - A bot_req still high in the cycle after ack is treated as a new request.
- Starvation:
  - The wait counter (8-bit, saturating at 255) increments each cycle in which the FSM is in B_IDLE, bot_req = 1 and vid_req = 1.
  - It clears on bot grant.
  - bot_starved sets when the counter reaches STARVE_MAX and stays set until reset.
  - Video priority is never overridden.
- Back-to-back video requests are accepted every cycle at full throughput. Bot throughput is at most one request per L+1 cycles.
- Reset mid-operation clears all in-flight tags and produces no ack. The requester keeps bot_req high and is re-granted after reset deasserts.
- Simultaneous vid_req and bot_req in B_IDLE: video wins, and bot waits with no lost request.

Test Plan:
- Reset, then RD_LAT=1 (L=3), single vid_req with vid_addr=0x0105 at cycle 0 -> mem_addr=0x0105 after edge 1; vid_valid=1 at cycle 3 with vid_data = memory[0x0105]; bot_ack stays 0.
- vid_on_in pattern 1,1,0,1 over cycles 0-3 -> vid_on_out 1,1,0,1 over cycles 3-6; all 0 before cycle 3.
- bot_req with bot_addr=0x3FFF, no video -> bot_ack is a single pulse at cycle 3 with bot_data = memory[0x3FFF]. Holding bot_req re-grants at cycle 4, giving the next ack at cycle 7.
- vid_req continuous for 20 cycles with bot_req high, STARVE_MAX=16 -> no bot grant, bot_starved=1 from the 16th denied cycle. After vid_req drops, bot is granted and acked 3 cycles later. bot_starved stays 1.
- Alternating vid_req (even cycles) with bot_req held -> bot granted on the first odd cycle. Video responses appear every even cycle +3 and are never displaced; exactly one bot_ack.
- Assert reset while a bot tag is in flight -> all outputs 0 immediately; no bot_ack. After release with bot_req held, the request is re-granted and acked L cycles later.

Source files
------------

// File: rtl/world_map_arbiter.sv
// world_map_arbiter: shares the world map memory read port between the
// display scanner (strict priority, fixed latency) and the robot sensor
// lookups (req/ack handshake that fills idle slots).
`timescale 1ns/1ps

module world_map_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_on_in,
    output logic              vid_valid,
    output logic [1:0]        vid_data,
    output logic              vid_on_out,
    input  logic              bot_req,
    input  logic [ADDR_W-1:0] bot_addr,
    output logic              bot_ack,
    output logic [1:0]        bot_data,
    output logic              bot_starved,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data
);

    // End-to-end latency from grant cycle to registered result.
    localparam int L = RD_LAT + 2;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        B_IDLE,
        B_WAIT,
        B_ACK
    } bot_state_t;

    // One in-flight read: whether a grant happened and who owns it.
    typedef struct packed {
        logic valid;
        logic bot;
    } tag_t;

    bot_state_t        bot_state;
    tag_t [L-2:0]      tag_pipe;
    tag_t              new_tag;
    tag_t              out_tag;
    logic [L-1:0]      von_pipe;
    logic [7:0]        wait_cnt;
    logic [7:0]        wait_cnt_next;
    logic              vid_grant;
    logic              bot_grant;
    logic              bot_denied;

    // Video always wins; the bot only takes a slot when idle and no video.
    assign vid_grant  = vid_req;
    assign bot_grant  = !vid_req && (bot_state == B_IDLE) && bot_req;
    assign bot_denied = vid_req && (bot_state == B_IDLE) && bot_req;
    assign out_tag    = tag_pipe[L-2];
    assign vid_on_out = von_pipe[L-1];

    // Build the tag for this cycle's grant and the next wait count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        new_tag       = '0;
        wait_cnt_next = wait_cnt;
        new_tag.valid = vid_grant || bot_grant;
        new_tag.bot   = bot_grant;
        if (bot_grant) begin
            wait_cnt_next = '0;
        end else if (bot_denied && (wait_cnt != 8'hFF)) begin
            wait_cnt_next = wait_cnt + 8'd1;
        end
    end

    // Register the granted address toward the map memory.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            mem_addr <= '0;
        end else if (vid_grant) begin
            mem_addr <= vid_addr;
        end else if (bot_grant) begin
            mem_addr <= bot_addr;
        end
    end

    // Shift grant tags alongside the memory read latency.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the tag pipeline is reset so a reset mid-read can never release a stale ack.
        if (reset) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe <= {tag_pipe[L-3:0], new_tag};
        end
    end

    // Delay video_on by the full lookup latency so it lines up with vid_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            von_pipe <= '0;
        end else begin
            von_pipe <= {von_pipe[L-2:0], vid_on_in};
        end
    end

    // Capture display results when a video tag reaches the output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_valid <= 1'b0;
            vid_data  <= '0;
        end else begin
            vid_valid <= out_tag.valid && !out_tag.bot;
            if (out_tag.valid && !out_tag.bot) begin
                vid_data <= mem_data;
            end
        end
    end

    // Bot handshake FSM: one outstanding request, one-cycle ack pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bot_state <= B_IDLE;
            bot_ack   <= 1'b0;
            bot_data  <= '0;
        end else begin
            bot_ack <= 1'b0;
            case (bot_state)
                B_IDLE: begin
                    if (bot_grant) begin
                        bot_state <= B_WAIT;
                    end
                end
                B_WAIT: begin
                    if (out_tag.valid && out_tag.bot) begin
                        bot_state <= B_ACK;
                        bot_ack   <= 1'b1;
                        bot_data  <= mem_data;
                    end
                end
                B_ACK: begin
                    bot_state <= B_IDLE;
                end
                default: begin
                    bot_state <= B_IDLE;
                end
            endcase
        end
    end

    // Count consecutive denials; the starved flag is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            bot_starved <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_next;
            if (wait_cnt_next >= STARVE_LIM) begin
                bot_starved <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_world_map_arbiter.sv
// tb_world_map_arbiter: directed bench for world_map_arbiter with a
// one-cycle registered map memory (RD_LAT = 1, so L = 3).
`timescale 1ns/1ps

module tb_world_map_arbiter;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic              vid_on_in = 1'b0;
    logic              vid_valid;
    logic [1:0]        vid_data;
    logic              vid_on_out;
    logic              bot_req = 1'b0;
    logic [ADDR_W-1:0] bot_addr = '0;
    logic              bot_ack;
    logic [1:0]        bot_data;
    logic              bot_starved;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_data = '0;

    int checks = 0;
    int errors = 0;

    world_map_arbiter #(
        .ADDR_W     (ADDR_W),
        .RD_LAT     (1),
        .STARVE_MAX (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_on_in   (vid_on_in),
        .vid_valid   (vid_valid),
        .vid_data    (vid_data),
        .vid_on_out  (vid_on_out),
        .bot_req     (bot_req),
        .bot_addr    (bot_addr),
        .bot_ack     (bot_ack),
        .bot_data    (bot_data),
        .bot_starved (bot_starved),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data)
    );

    always #5 clk = ~clk;

    // Map contents: code = addr[1:0] + addr[13:12] (mod 4), one-cycle read.
    function automatic logic [1:0] map_code(input logic [ADDR_W-1:0] a);
        return a[1:0] + a[13:12];
    endfunction

    always @(posedge clk) begin
        mem_data <= map_code(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_vid_valid", 32'(vid_valid), 32'd0);
        check("rst_vid_data", 32'(vid_data), 32'd0);
        check("rst_vid_on_out", 32'(vid_on_out), 32'd0);
        check("rst_bot_ack", 32'(bot_ack), 32'd0);
        check("rst_bot_data", 32'(bot_data), 32'd0);
        check("rst_bot_starved", 32'(bot_starved), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);

        // ---------------- single video lookup + vid_on alignment ----------------
        reset = 1'b0;
        // cycle 0
        vid_req = 1'b1; vid_addr = 14'h0105; vid_on_in = 1'b1;
        check("v1_c0_valid", 32'(vid_valid), 32'd0);
        check("v1_c0_von", 32'(vid_on_out), 32'd0);
        tick(); // cycle 1
        vid_req = 1'b0; vid_on_in = 1'b1;
        check("v1_mem_addr", 32'(mem_addr), 32'h0105);
        check("v1_c1_valid", 32'(vid_valid), 32'd0);
        check("v1_c1_von", 32'(vid_on_out), 32'd0);
        tick(); // cycle 2
        vid_on_in = 1'b0;
        check("v1_c2_valid", 32'(vid_valid), 32'd0);
        check("v1_c2_von", 32'(vid_on_out), 32'd0);
        tick(); // cycle 3
        vid_on_in = 1'b1;
        check("v1_c3_valid", 32'(vid_valid), 32'd1);
        check("v1_c3_data", 32'(vid_data), 32'd1);
        check("v1_c3_von", 32'(vid_on_out), 32'd1);
        check("v1_c3_bot_ack", 32'(bot_ack), 32'd0);
        tick(); // cycle 4
        vid_on_in = 1'b0;
        check("v1_c4_valid", 32'(vid_valid), 32'd0);
        check("v1_c4_von", 32'(vid_on_out), 32'd1);
        tick(); // cycle 5
        check("v1_c5_von", 32'(vid_on_out), 32'd0);
        tick(); // cycle 6
        check("v1_c6_von", 32'(vid_on_out), 32'd1);
        tick(); // cycle 7
        check("v1_c7_von", 32'(vid_on_out), 32'd0);
        check("v1_c7_bot_ack", 32'(bot_ack), 32'd0);

        // ---------------- bot lookup, held request re-granted ----------------
        bot_addr = 14'h3FFF;
        for (int c = 0; c < 10; c++) begin
            bot_req = (c < 7);
            check($sformatf("b1_ack_c%0d", c), 32'(bot_ack), 32'((c == 3) || (c == 7)));
            if ((c == 3) || (c == 7)) begin
                check($sformatf("b1_data_c%0d", c), 32'(bot_data), 32'd2);
            end
            if (c == 1) begin
                check("b1_mem_addr", 32'(mem_addr), 32'h3FFF);
            end
            check($sformatf("b1_vid_valid_c%0d", c), 32'(vid_valid), 32'd0);
            tick();
        end
        check("b1_vid_data_hold", 32'(vid_data), 32'd1);

        // ---------------- alternating video, bot fills first odd slot ----------------
        bot_addr = 14'h0003;
        for (int c = 0; c < 12; c++) begin
            vid_req  = ((c % 2) == 0) && (c < 10);
            vid_addr = 14'h1000 + 14'(c / 2);
            bot_req  = (c < 4);
            check($sformatf("alt_ack_c%0d", c), 32'(bot_ack), 32'(c == 4));
            if (c == 4) begin
                check("alt_bot_data", 32'(bot_data), 32'd3);
            end
            if (c == 2) begin
                check("alt_mem_addr", 32'(mem_addr), 32'h0003);
            end
            check($sformatf("alt_vvalid_c%0d", c), 32'(vid_valid), 32'((c >= 3) && ((c % 2) == 1)));
            if ((c >= 3) && ((c % 2) == 1)) begin
                check($sformatf("alt_vdata_c%0d", c), 32'(vid_data), 32'((((c - 3) / 2) & 3) + 1) & 32'd3);
            end
            tick();
        end

        // ---------------- starvation under continuous video ----------------
        bot_addr = 14'h1002;
        for (int c = 0; c < 26; c++) begin
            vid_req  = (c < 20);
            vid_addr = 14'h2000 + 14'(c);
            bot_req  = (c < 23);
            check($sformatf("st_ack_c%0d", c), 32'(bot_ack), 32'(c == 23));
            check($sformatf("st_starved_c%0d", c), 32'(bot_starved), 32'(c >= 16));
            check($sformatf("st_vvalid_c%0d", c), 32'(vid_valid), 32'((c >= 3) && (c < 23)));
            if ((c >= 3) && (c < 23)) begin
                check($sformatf("st_vdata_c%0d", c), 32'(vid_data), 32'((c - 1) & 3));
            end
            if (c == 21) begin
                check("st_mem_addr", 32'(mem_addr), 32'h1002);
            end
            if (c == 23) begin
                check("st_bot_data", 32'(bot_data), 32'd3);
            end
            tick();
        end

        // ---------------- reset with a bot tag in flight ----------------
        bot_addr = 14'h0106;
        bot_req  = 1'b1;
        tick(); // cycle 1
        check("rr_mem_addr", 32'(mem_addr), 32'h0106);
        tick(); // cycle 2: bot tag at output stage
        reset = 1'b1;
        #1;
        check("rr_vid_valid", 32'(vid_valid), 32'd0);
        check("rr_vid_data", 32'(vid_data), 32'd0);
        check("rr_vid_on_out", 32'(vid_on_out), 32'd0);
        check("rr_bot_ack", 32'(bot_ack), 32'd0);
        check("rr_bot_data", 32'(bot_data), 32'd0);
        check("rr_bot_starved", 32'(bot_starved), 32'd0);
        check("rr_mem_addr0", 32'(mem_addr), 32'd0);
        tick();
        check("rr_held_ack", 32'(bot_ack), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bot_req = (c < 3);
            check($sformatf("rr_ack_c%0d", c), 32'(bot_ack), 32'(c == 3));
            if (c == 3) begin
                check("rr_bot_data_ack", 32'(bot_data), 32'd2);
            end
            if (c == 1) begin
                check("rr_regrant_addr", 32'(mem_addr), 32'h0106);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
